// File: rtl/ones_frame_accumulator.sv
// Sums per-byte ones counts and beats over an in_last-delimited frame and presents
// {total, beats, ovf} on a valid/ready port. Define ONES_ACC_SAT_EN to saturate the total instead of wrapping.
module ones_frame_accumulator #(
  parameter int CNT_W  = 4,
  parameter int ACC_W  = 16,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [BEAT_W-1:0] out_beats,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state, state_next;
  logic [ACC_W-1:0]  acc;
  logic [BEAT_W-1:0] beats;
  logic              ovf;

  logic              accept;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic [ACC_W-1:0]  total_next;
  logic              beat_sat;
  logic [BEAT_W-1:0] beats_next;
  logic              ovf_next;

  assign accept = in_valid & in_ready;

  // One extra bit of headroom so the carry out of the running total is visible.
  assign sum   = {1'b0, acc} + (ACC_W+1)'(cnt_in);
  assign carry = sum[ACC_W];

`ifdef ONES_ACC_SAT_EN
  assign total_next = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign total_next = sum[ACC_W-1:0];
`endif

  // The counter sticks at all-ones; trying to count past it is the overflow.
  assign beat_sat   = &beats;
  assign beats_next = beat_sat ? beats : beats + BEAT_W'(1);
  assign ovf_next   = ovf | carry | beat_sat;

  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && in_last) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // The result is only presented while holding, so out_valid is simply the state.
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      beats     <= '0;
      ovf       <= 1'b0;
      out_total <= '0;
      out_beats <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_total <= total_next;
        out_beats <= beats_next;
        out_ovf   <= ovf_next;
        acc       <= '0;
        beats     <= '0;
        ovf       <= 1'b0;
      end else begin
        acc       <= total_next;
        beats     <= beats_next;
        ovf       <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_ones_frame_accumulator.sv
// Directed bench for ones_frame_accumulator: a default-width instance and a narrow
// (ACC_W=4, BEAT_W=2) instance share the same stimulus; both are checked frame by frame.
module tb_ones_frame_accumulator;

`ifdef ONES_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cnt_in;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [15:0] out_total_a;
  logic [7:0]  out_beats_a;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [3:0]  out_total_b;
  logic [1:0]  out_beats_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ones_frame_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_a), .out_total(out_total_a), .out_beats(out_beats_a),
    .out_ovf(out_ovf_a), .out_valid(out_valid_a), .out_ready(out_ready)
  );

  ones_frame_accumulator #(.CNT_W(4), .ACC_W(4), .BEAT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_b), .out_total(out_total_b), .out_beats(out_beats_b),
    .out_ovf(out_ovf_b), .out_valid(out_valid_b), .out_ready(out_ready)
  );

  typedef struct {
    int         n;
    logic [3:0] cnts [6];
    int         a_total, a_beats, a_ovf;
    int         b_total_wrap, b_total_sat, b_beats, b_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
    cnt_in   = '0;
  endtask

  // Drive one beat for a cycle, starting at a negedge.
  task automatic send_beat(input logic [3:0] c, input logic last, input string tag);
    @(negedge clk);
    cnt_in   = c;
    in_valid = 1'b1;
    in_last  = last;
    #1;
    check({tag, ".in_ready"}, int'(in_ready_a & in_ready_b), 1);
    check({tag, ".no_early_valid"}, int'(out_valid_a | out_valid_b), 0);
  endtask

  task automatic check_result(input string tag, input int at, input int ab, input int ao,
                              input int bt, input int bb, input int bo);
    check({tag, ".a_valid"}, int'(out_valid_a), 1);
    check({tag, ".a_total"}, int'(out_total_a), at);
    check({tag, ".a_beats"}, int'(out_beats_a), ab);
    check({tag, ".a_ovf"},   int'(out_ovf_a),   ao);
    check({tag, ".b_valid"}, int'(out_valid_b), 1);
    check({tag, ".b_total"}, int'(out_total_b), bt);
    check({tag, ".b_beats"}, int'(out_beats_b), bb);
    check({tag, ".b_ovf"},   int'(out_ovf_b),   bo);
    check({tag, ".in_ready_hold"}, int'(in_ready_a | in_ready_b), 0);
  endtask

  // Result observed, out_ready high: one cycle later valid must drop and input reopen.
  task automatic check_drained(input string tag);
    @(negedge clk);
    #1;
    check({tag, ".valid_dropped"}, int'(out_valid_a | out_valid_b), 0);
    check({tag, ".in_ready_back"}, int'(in_ready_a & in_ready_b), 1);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    for (int i = 0; i < v.n; i++) send_beat(v.cnts[i], (i == v.n - 1), tag);
    @(negedge clk);
    idle_inputs();
    #1;
    check_result(tag, v.a_total, v.a_beats, v.a_ovf,
                 SAT ? v.b_total_sat : v.b_total_wrap, v.b_beats, v.b_ovf);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    #1;
    check({tag, ".rst_valid"},    int'(out_valid_a | out_valid_b), 0);
    check({tag, ".rst_in_ready"}, int'(in_ready_a & in_ready_b), 1);
    check({tag, ".rst_total"},    int'(out_total_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t one_two;

    vecs[0] = '{n:3, cnts:'{4'd3, 4'd8, 4'd0, 4'd0, 4'd0, 4'd0},
                a_total:11, a_beats:3, a_ovf:0, b_total_wrap:11, b_total_sat:11, b_beats:3, b_ovf:0};
    vecs[1] = '{n:1, cnts:'{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
                a_total:5, a_beats:1, a_ovf:0, b_total_wrap:5, b_total_sat:5, b_beats:1, b_ovf:0};
    vecs[2] = '{n:3, cnts:'{4'd8, 4'd8, 4'd1, 4'd0, 4'd0, 4'd0},
                a_total:17, a_beats:3, a_ovf:0, b_total_wrap:1, b_total_sat:15, b_beats:3, b_ovf:1};
    vecs[3] = '{n:1, cnts:'{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0},
                a_total:2, a_beats:1, a_ovf:0, b_total_wrap:2, b_total_sat:2, b_beats:1, b_ovf:0};
    vecs[4] = '{n:5, cnts:'{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0},
                a_total:5, a_beats:5, a_ovf:0, b_total_wrap:5, b_total_sat:5, b_beats:3, b_ovf:1};
    vecs[5] = '{n:6, cnts:'{4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8},
                a_total:48, a_beats:6, a_ovf:0, b_total_wrap:0, b_total_sat:15, b_beats:3, b_ovf:1};
    one_two = vecs[3];

    rst_n     = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    #1;
    check("reset.valid",    int'(out_valid_a | out_valid_b), 0);
    check("reset.in_ready", int'(in_ready_a & in_ready_b), 1);
    check("reset.total",    int'(out_total_a), 0);
    check("reset.beats",    int'(out_beats_a), 0);
    check("reset.ovf",      int'(out_ovf_a | out_ovf_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
      check_drained($sformatf("vec%0d", i));
    end

    // Idle gap: a partial frame must survive in_valid low.
    send_beat(4'd6, 1'b0, "gap");
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    send_beat(4'd1, 1'b1, "gap");
    @(negedge clk);
    idle_inputs();
    #1;
    check_result("gap", 7, 2, 0, 7, 2, 0);
    check_drained("gap");

    // Backpressure: result held for 4 cycles, stray input ignored, no combinational in_ready.
    out_ready = 1'b0;
    send_beat(4'd4, 1'b0, "bp");
    send_beat(4'd4, 1'b1, "bp");
    @(negedge clk);
    cnt_in   = 4'd7;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_result($sformatf("bp%0d", k), 8, 2, 0, 8, 2, 0);
      @(negedge clk);
    end
    idle_inputs();
    out_ready = 1'b1;
    #1;
    check("bp.no_comb_ready", int'(in_ready_a | in_ready_b), 0);
    check_drained("bp");

    // Reset mid-frame after two beats.
    send_beat(4'd3, 1'b0, "rst_mid");
    send_beat(4'd3, 1'b0, "rst_mid");
    pulse_reset("rst_mid");
    run_frame(one_two, "after_rst_mid");
    check_drained("after_rst_mid");

    // Reset while holding an unacknowledged result.
    out_ready = 1'b0;
    send_beat(4'd7, 1'b1, "rst_hold");
    @(negedge clk);
    idle_inputs();
    #1;
    check("rst_hold.valid_before", int'(out_valid_a), 1);
    pulse_reset("rst_hold");
    out_ready = 1'b1;
    run_frame(one_two, "after_rst_hold");
    check_drained("after_rst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
